// File: rtl/log_offset_arbiter.sv
// log_offset_arbiter
//   Round-robin front end that lets NUM_REQ log-domain converters share a
//   single 4-bit-offset log LUT. The granted offset is looked up and then
//   registered into a one-entry response slot. That slot is returned with
//   the requester ID on a valid/ready channel.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   en          allows new grants when high
//   req_valid   per-requester request valid             [NUM_REQ]
//   req_offset  per-requester offset, 4 bits each       [NUM_REQ*4]
//   req_ready   per-requester accept, at most one high  [NUM_REQ]
//   rsp_valid   response slot occupied
//   rsp_id      requester index owning the response     [IDX_W]
//   rsp_log     LUT result                              [24]
//   rsp_ready   downstream accepts the response
//   busy        mirror of rsp_valid
module log_offset_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*4-1:0]   req_offset,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  output logic [IDX_W-1:0]       rsp_id,
  output logic [23:0]            rsp_log,
  input  logic                   rsp_ready,
  output logic                   busy
);

  logic [IDX_W-1:0] rr_ptr;
  logic             slot_free;
  logic             arb_ok;
  logic             grant_found;
  logic             accept;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] rr_next;
  logic [3:0]       grant_offset;
  logic [23:0]      grant_log;

  function automatic logic [23:0] lut_log_offset(input logic [3:0] offset);
    logic [23:0] val;
    case (offset)
      4'd0, 4'd1: val = 24'h000000;
      4'd2:       val = 24'hA98A98;
      4'd3:       val = 24'hF44F44;
      default:    val = 24'h100100;
    endcase
    return val;
  endfunction

  // The slot can take a new entry when it is empty or is being drained in
  // this same cycle. That gives back-to-back responses with no bubble.
  assign slot_free = !rsp_valid || rsp_ready;
  // Gating with rst keeps req_ready low for the whole reset.
  assign arb_ok    = en && slot_free && !rst;

  // Rotating priority. First search indices at or above rr_ptr. If none is
  // valid, wrap around and search the indices below rr_ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[i] && (IDX_W'(i) >= rr_ptr)) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[i] && (IDX_W'(i) < rr_ptr)) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
  end

  assign accept = arb_ok && grant_found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    grant_offset = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) grant_offset = req_offset[4*i +: 4];
    end
  end

  assign grant_log = lut_log_offset(grant_offset);
  assign rr_next   = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_log   <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_id    <= grant_idx;
      rsp_log   <= grant_log;
      rr_ptr    <= rr_next;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign busy = rsp_valid;

endmodule

// File: tb/tb_log_offset_arbiter.sv
module tb_log_offset_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic [1:0]  id;
    logic [23:0] log;
  } rsp_t;

  logic           clk;
  logic           rst;
  logic           en;
  logic [N-1:0]   req_valid;
  logic [N*4-1:0] req_offset;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [23:0]    rsp_log;
  logic           rsp_ready;
  logic           busy;

  int   n_cmp = 0;
  int   n_err = 0;
  int   m_rr  = 0;
  rsp_t sb[$];

  log_offset_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req_valid  (req_valid),
    .req_offset (req_offset),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_log    (rsp_log),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] exp_lut(input logic [3:0] off);
    if (off == 4'd2) return 24'hA98A98;
    if (off == 4'd3) return 24'hF44F44;
    if (off >= 4'd4) return 24'h100100;
    return 24'h000000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle. Inputs have already been driven. The bench predicts the
  // grant and checks the outputs mid-cycle. It then updates its own
  // scoreboard and pointer, and returns 1 time unit after the rising edge.
  task automatic step(input string tag);
    logic [N-1:0] exp_ready;
    logic         m_valid;
    int           g;
    int           idx;
    rsp_t         item;
    exp_ready = '0;
    g = -1;
    m_valid = (sb.size() != 0);
    if (en && (!m_valid || rsp_ready)) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
      if (g >= 0) exp_ready[g] = 1'b1;
    end
    @(negedge clk);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(exp_ready));
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(m_valid));
    chk({tag, ".busy"}, 32'(busy), 32'(m_valid));
    if (m_valid) begin
      chk({tag, ".rsp_id"}, 32'(rsp_id), 32'(sb[0].id));
      chk({tag, ".rsp_log"}, 32'(rsp_log), 32'(sb[0].log));
    end
    if (m_valid && rsp_ready) void'(sb.pop_front());
    if (g >= 0) begin
      item.id  = 2'(g);
      item.log = exp_lut(req_offset[4*g +: 4]);
      sb.push_back(item);
      m_rr = (g + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_off(input int r, input logic [3:0] v);
    req_offset[4*r +: 4] = v;
  endtask

  initial begin
    logic [3:0] sweep [5];
    logic [1:0] fair_ids [6];
    sweep    = '{4'd0, 4'd1, 4'd3, 4'd7, 4'd15};
    fair_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // Reset state; requests during reset must not be granted.
    rst = 1'b1; en = 1'b1; req_valid = '1; req_offset = '0; rsp_ready = 1'b1;
    #1;
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_id", 32'(rsp_id), 32'd0);
    chk("rst.rsp_log", 32'(rsp_log), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0; req_valid = '0;
    m_rr = 0;

    // 1: single request, 1-cycle latency.
    req_valid = 4'b0001; set_off(0, 4'd2);
    step("t1.acc");
    chk("t1.lat_valid", 32'(rsp_valid), 32'd1);
    chk("t1.lat_id", 32'(rsp_id), 32'd0);
    chk("t1.lat_log", 32'(rsp_log), 32'hA98A98);
    req_valid = '0;
    step("t1.drain");
    step("t1.idle");

    // 2: LUT sweep through requester 1, back-to-back.
    req_valid = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      set_off(1, sweep[i]);
      step("t2.sweep");
      chk("t2.held_valid", 32'(rsp_valid), 32'd1);
      chk("t2.log", 32'(rsp_log), 32'(exp_lut(sweep[i])));
    end
    req_valid = '0;
    step("t2.drain");
    step("t2.idle");

    // 3: fairness after reset.
    rst = 1'b1; #1; rst = 1'b0; sb.delete(); m_rr = 0;
    for (int r = 0; r < N; r++) set_off(r, 4'(r + 2));
    req_valid = '1;
    for (int i = 0; i < 6; i++) begin
      step("t3.fair");
      chk("t3.id_seq", 32'(rsp_id), 32'(fair_ids[i]));
    end
    req_valid = '0;
    step("t3.drain");

    // 4: backpressure with id2/F44F44 pending, then same-cycle grant to req3.
    req_valid = 4'b0100; set_off(2, 4'd3); rsp_ready = 1'b0;
    step("t4.acc2");
    req_valid = 4'b1000; set_off(3, 4'd7);
    for (int i = 0; i < 3; i++) begin
      step("t4.stall");
      chk("t4.hold_id", 32'(rsp_id), 32'd2);
      chk("t4.hold_log", 32'(rsp_log), 32'hF44F44);
    end
    rsp_ready = 1'b1;
    step("t4.release");
    chk("t4.next_id", 32'(rsp_id), 32'd3);
    req_valid = '0;

    // 5: en low drains the pending response without granting; en high grants req0 at once.
    en = 1'b0; req_valid = 4'b0001; set_off(0, 4'd4);
    step("t5.en0_drain");
    step("t5.en0_idle");
    chk("t5.no_rsp", 32'(rsp_valid), 32'd0);
    en = 1'b1;
    step("t5.en1_grant");
    chk("t5.id0", 32'(rsp_id), 32'd0);
    req_valid = '0; rsp_ready = 1'b0;

    // 6: reset while a response is pending.
    rst = 1'b1; #1;
    chk("t6.rst_valid", 32'(rsp_valid), 32'd0);
    chk("t6.rst_log", 32'(rsp_log), 32'd0);
    chk("t6.rst_ready", 32'(req_ready), 32'd0);
    sb.delete(); m_rr = 0;
    @(posedge clk); #1;
    rst = 1'b0; rsp_ready = 1'b1; req_valid = '1;
    step("t6.first");
    chk("t6.first_id", 32'(rsp_id), 32'd0);
    req_valid = '0;
    step("t6.drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
